// File: rtl/mux_scan_sequencer_pkg.sv
// Shared state encodings and widths for the 16-input mux scanner.
package mux_scan_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE_W = 2'd1,
        SAMPLE   = 2'd2,
        DONE     = 2'd3
    } scan_state_e;

    localparam int          SEL_W    = 4;
    localparam int          DATA_W   = 16;
    localparam logic [3:0]  SEL_LAST = 4'd15;

endpackage

// File: rtl/mux_scan_settle_cnt.sv
// 3-bit loadable down-counter whose zero flag ends the per-select settle wait.
module mux_scan_settle_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [2:0] cnt_r;

    // Count register: load wins over decrement, and the count never wraps below zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 3'd0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != 3'd0)) begin
            cnt_r <= cnt_r - 3'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == 3'd0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps a 16:1 mux select through 0..15, samples its output per select value,
// and publishes the assembled word with a start/busy/done handshake.
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mux_out,
    output logic [0:3]  sel,
    output logic [0:15] data_out,
    output logic        busy,
    output logic        done
);

    // The counter holds SETTLE-1 so SETTLE_W lasts exactly SETTLE cycles.
    localparam logic       HAS_SETTLE  = (SETTLE > 0);
    localparam logic [2:0] SETTLE_LOAD = (SETTLE > 0) ? 3'(SETTLE - 1) : 3'd0;

    scan_state_e        state_r, state_s;
    logic [0:SEL_W-1]   sel_r, sel_s;
    logic [0:DATA_W-1]  cap_r, cap_s;
    logic [0:DATA_W-1]  data_r, data_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               load_s, dec_s, zero_s;

    mux_scan_settle_cnt u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_val (SETTLE_LOAD),
        .dec      (dec_s),
        .zero     (zero_s)
    );

    // State and datapath registers; reset aborts any scan in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            sel_r   <= 4'd0;
            cap_r   <= 16'h0000;
            data_r  <= 16'h0000;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            sel_r   <= sel_s;
            cap_r   <= cap_s;
            data_r  <= data_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state and next-output decode; mux_out only reaches data, never control.
    always_comb begin
        state_s = state_r;
        sel_s   = sel_r;
        cap_s   = cap_r;
        data_s  = data_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        load_s  = 1'b0;
        dec_s   = 1'b0;
        case (state_r)
            IDLE: begin
                sel_s  = 4'd0;
                busy_s = 1'b0;
                if (start) begin
                    busy_s = 1'b1;
                    if (HAS_SETTLE) begin
                        state_s = SETTLE_W;
                        load_s  = 1'b1;
                    end else begin
                        state_s = SAMPLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SETTLE_W: begin
                if (zero_s) begin
                    state_s = SAMPLE;
                end else begin
                    dec_s = 1'b1;
                end
            end
            SAMPLE: begin
                cap_s[sel_r] = mux_out;
                if (sel_r == SEL_LAST) begin
                    sel_s   = 4'd0;
                    data_s  = {cap_r[0:DATA_W-2], mux_out};
                    done_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    sel_s = sel_r + 4'd1;
                    if (HAS_SETTLE) begin
                        state_s = SETTLE_W;
                        load_s  = 1'b1;
                    end else begin
                        state_s = SAMPLE;
                    end
                end
            end
            DONE: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                sel_s   = 4'd0;
                busy_s  = 1'b0;
            end
        endcase
    end

    assign sel      = sel_r;
    assign data_out = data_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench: two scanner instances (SETTLE=0 and SETTLE=2), each beside a modelled 16:1 mux.
module tb_mux_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0, start2 = 1'b0;
    logic [0:15] bank0 = 16'h0000, bank2 = 16'h0000;
    logic        mux0, mux2;
    logic [0:3]  sel0, sel2;
    logic [0:15] data0, data2;
    logic        busy0, busy2, done0, done2;
    int          n_cmp = 0;
    int          n_err = 0;
    int          dcnt0 = 0;

    always #5 clk = ~clk;

    assign mux0 = bank0[sel0];
    assign mux2 = bank2[sel2];

    mux_scan_sequencer #(.SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .mux_out(mux0),
        .sel(sel0), .data_out(data0), .busy(busy0), .done(done0)
    );

    mux_scan_sequencer #(.SETTLE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mux_out(mux2),
        .sel(sel2), .data_out(data2), .busy(busy2), .done(done2)
    );

    always @(negedge clk) begin
        if (done0 === 1'b1) dcnt0 = dcnt0 + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done0(input int limit, output int n);
        n = 0;
        while (n < limit && done0 !== 1'b1) begin
            step();
            n++;
        end
        check_eq("done0_timeout", 32'(done0), 32'd1);
    endtask

    initial begin
        int n, n2, d_before;

        // Power-on reset
        step(); step();
        check_eq("por_sel", 32'(sel0), 32'd0);
        check_eq("por_data", 32'(data0), 32'd0);
        check_eq("por_busy", 32'(busy0), 32'd0);
        check_eq("por_done", 32'(done0), 32'd0);
        rst = 1'b0;
        step();

        // Single scan, SETTLE=0
        bank0 = 16'b1010_0000_0000_0001;
        d_before = dcnt0;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        check_eq("s0_accept_busy", 32'(busy0), 32'd1);
        check_eq("s0_accept_sel", 32'(sel0), 32'd0);
        for (int i = 1; i < 16; i++) begin
            step();
            check_eq("s0_sel_step", 32'(sel0), 32'(i));
            check_eq("s0_no_early_done", 32'(done0), 32'd0);
        end
        step();
        check_eq("s0_done", 32'(done0), 32'd1);
        check_eq("s0_busy_in_done", 32'(busy0), 32'd1);
        check_eq("s0_data", 32'(data0), 32'hA001);
        check_eq("s0_sel_wrap", 32'(sel0), 32'd0);
        step();
        check_eq("s0_done_clear", 32'(done0), 32'd0);
        check_eq("s0_busy_clear", 32'(busy0), 32'd0);
        check_eq("s0_one_done", 32'(dcnt0 - d_before), 32'd1);

        // Asynchronous reset while idle with a non-zero word held
        #2 rst = 1'b1;
        #1;
        check_eq("rst_data", 32'(data0), 32'd0);
        check_eq("rst_sel", 32'(sel0), 32'd0);
        check_eq("rst_busy", 32'(busy0), 32'd0);
        check_eq("rst_done", 32'(done0), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Walking one, SETTLE=2: every select held three cycles
        bank2 = 16'b0000_0000_0001_0000;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        check_eq("s2_sel0", 32'(sel2), 32'd0);
        for (int j = 1; j < 48; j++) begin
            step();
            check_eq("s2_sel_hold", 32'(sel2), 32'(j / 3));
            check_eq("s2_no_early_done", 32'(done2), 32'd0);
        end
        step();
        check_eq("s2_done", 32'(done2), 32'd1);
        check_eq("s2_data", 32'(data2), 32'h0010);
        step();
        check_eq("s2_busy_clear", 32'(busy2), 32'd0);

        // Start while busy is ignored
        bank0 = 16'h1234;
        d_before = dcnt0;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check_eq("busy_sel7", 32'(sel0), 32'd7);
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int i = 0; i < 30; i++) step();
        check_eq("busy_one_done", 32'(dcnt0 - d_before), 32'd1);
        check_eq("busy_idle_after", 32'(busy0), 32'd0);
        check_eq("busy_data", 32'(data0), 32'h1234);

        // Abort at sel=9
        bank0 = 16'hFFFF;
        d_before = dcnt0;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int i = 0; i < 9; i++) step();
        check_eq("abort_sel9", 32'(sel0), 32'd9);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_data", 32'(data0), 32'd0);
        check_eq("abort_busy", 32'(busy0), 32'd0);
        check_eq("abort_sel", 32'(sel0), 32'd0);
        step(); step();
        rst = 1'b0;
        step(); step();
        check_eq("abort_no_done", 32'(dcnt0 - d_before), 32'd0);
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        wait_done0(40, n);
        check_eq("abort_rescan_data", 32'(data0), 32'hFFFF);
        step(); step();

        // Back-to-back with start held high
        bank0 = 16'h5A5A;
        start0 = 1'b1;
        wait_done0(40, n);
        check_eq("b2b_data1", 32'(data0), 32'h5A5A);
        bank0 = 16'hA5A5;
        step();
        check_eq("b2b_gap_done_low", 32'(done0), 32'd0);
        wait_done0(40, n2);
        check_eq("b2b_spacing", 32'(1 + n2), 32'd18);
        check_eq("b2b_data2", 32'(data0), 32'hA5A5);
        start0 = 1'b0;
        step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
